// File: rtl/cpu_types.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types
// Description : Shared types for the RAM port arbiter (access size, FSM state).
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

    localparam int MEM_ADDR_LSB = 2;

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter_if
// Description : Fetch, load/store and RAM-side signals of the RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_misaligned;

    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [3:0]  mem_wbe;
    logic [31:0] mem_rd;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_unsigned, mem_rd,
        output if_ready, if_rdata, d_ready, d_rdata, d_misaligned,
        output mem_we, mem_a, mem_wd, mem_wbe
    );

    // Requester / RAM side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_unsigned, mem_rd,
        input  if_ready, if_rdata, d_ready, d_rdata, d_misaligned,
        input  mem_we, mem_a, mem_wd, mem_wbe
    );

endinterface
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Alignment check, store lane steering and load extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import cpu_types::*;
(
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    input  logic        i_unsigned,
    output logic        o_misaligned,
    output logic [3:0]  o_wbe,
    output logic [31:0] o_wd,
    output logic [31:0] o_ld
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte       = 8'(i_rdata >> {i_offset, 3'b000});
        w_half       = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_misaligned = 1'b0;
        o_wbe        = 4'hF;
        o_wd         = i_wdata;
        o_ld         = i_rdata;
        // Size encoding 3 falls through to the word case
        case (i_size)
            BYTE: begin
                o_wbe = 4'b0001 << i_offset;
                o_wd  = {4{i_wdata[7:0]}};
                o_ld  = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            HALF: begin
                o_misaligned = i_offset[0];
                o_wbe        = 4'b0011 << i_offset;
                o_wd         = {2{i_wdata[15:0]}};
                o_ld         = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: begin
                o_misaligned = |i_offset;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Round-robin sharing of one single-port RAM between fetch and
//               load/store requesters, two cycles per access.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import cpu_types::*;
(
    input  logic               clk,
    input  logic               rst_n,
    ram_port_arbiter_if.slave  bus
);

    arb_state_t  r_state;
    logic        r_last_d;
    logic        r_if_ready;
    logic        r_d_ready;
    logic        r_d_misaligned;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    logic        w_grant_d;
    logic        w_grant_f;
    logic        w_misaligned;
    logic [3:0]  w_wbe;
    logic [31:0] w_wd;
    logic [31:0] w_ld;
    logic        w_unused_if_lsbs;

    assign w_unused_if_lsbs = ^bus.if_addr[MEM_ADDR_LSB-1:0];

    mem_lane_align u_align (
        .i_offset     (bus.d_addr[1:0]),
        .i_size       (bus.d_size),
        .i_wdata      (bus.d_wdata),
        .i_rdata      (bus.mem_rd),
        .i_unsigned   (bus.d_unsigned),
        .o_misaligned (w_misaligned),
        .o_wbe        (w_wbe),
        .o_wd         (w_wd),
        .o_ld         (w_ld)
    );

    // Data loses a tie only when it also took the previous grant
    always_comb begin
        w_grant_d = (r_state == IDLE) && bus.d_req && !(bus.if_req && r_last_d);
        w_grant_f = (r_state == IDLE) && bus.if_req && !w_grant_d;
    end

    always_comb begin
        bus.mem_we  = 1'b0;
        bus.mem_a   = 32'h0;
        bus.mem_wd  = 32'h0;
        bus.mem_wbe = 4'h0;
        if (w_grant_f) begin
            bus.mem_a = {bus.if_addr[31:MEM_ADDR_LSB], {MEM_ADDR_LSB{1'b0}}};
        end else if (w_grant_d) begin
            bus.mem_a = {bus.d_addr[31:MEM_ADDR_LSB], {MEM_ADDR_LSB{1'b0}}};
            if (bus.d_we && !w_misaligned) begin
                bus.mem_we  = 1'b1;
                bus.mem_wbe = w_wbe;
                bus.mem_wd  = w_wd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_last_d       <= 1'b0;
            r_if_ready     <= 1'b0;
            r_d_ready      <= 1'b0;
            r_d_misaligned <= 1'b0;
            r_if_rdata     <= 32'h0;
            r_d_rdata      <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d || w_grant_f) begin
                        r_state    <= RESP;
                        r_last_d   <= w_grant_d;
                        r_if_ready <= w_grant_f;
                        r_d_ready  <= w_grant_d;
                        if (w_grant_f) begin
                            r_if_rdata <= bus.mem_rd;
                        end
                        if (w_grant_d) begin
                            r_d_misaligned <= w_misaligned;
                            r_d_rdata      <= (bus.d_we || w_misaligned) ? 32'h0 : w_ld;
                        end
                    end
                end
                RESP: begin
                    r_state        <= IDLE;
                    r_if_ready     <= 1'b0;
                    r_d_ready      <= 1'b0;
                    r_d_misaligned <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_ready     = r_if_ready;
    assign bus.if_rdata     = r_if_rdata;
    assign bus.d_ready      = r_d_ready;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.d_misaligned = r_d_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Directed and randomized bench for ram_port_arbiter with a
//               byte-level reference model of arbitration and RAM contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_port_arbiter_if bus ();

    ram_port_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] ram    [128];
    logic [7:0]  shadow [512];

    assign bus.mem_rd = ram[bus.mem_a[8:2]];

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.mem_wbe[k]) ram[bus.mem_a[8:2]][8*k +: 8] = bus.mem_wd[8*k +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a transaction-level view (who wins, what bytes move)
    // ------------------------------------------------------------------
    bit          m_valid = 0;
    bit          m_busy  = 0;
    bit          m_last_d = 0;
    bit          e_if_ready = 0, e_d_ready = 0, e_d_mis = 0;
    logic [31:0] e_if_rdata = 0, e_d_rdata = 0;

    always @(negedge clk) begin : model
        int          g, sz, o, base;
        logic [31:0] x_a, x_wd, v, n_if_rdata, n_d_rdata;
        logic [3:0]  x_wbe;
        logic        x_we, n_mis;
        bit          chk_a, chk_wd;

        if (m_valid) begin
            chk("if_ready", 32'(bus.if_ready), 32'(e_if_ready));
            chk("d_ready",  32'(bus.d_ready),  32'(e_d_ready));
            if (e_if_ready) chk("if_rdata", bus.if_rdata, e_if_rdata);
            if (e_d_ready) begin
                chk("d_rdata",      bus.d_rdata, e_d_rdata);
                chk("d_misaligned", 32'(bus.d_misaligned), 32'(e_d_mis));
            end
        end

        g = 0; x_we = 0; x_wbe = 0; x_a = 0; x_wd = 0; chk_a = 1; chk_wd = 1;
        n_if_rdata = 0; n_d_rdata = 0; n_mis = 0;
        if (!m_busy) begin
            if (bus.d_req && bus.if_req) g = m_last_d ? 1 : 2;
            else if (bus.d_req)          g = 2;
            else if (bus.if_req)         g = 1;
        end

        if (g == 1) begin
            chk_wd = 0;
            x_a    = bus.if_addr & ~32'h3;
            base   = int'(bus.if_addr[8:2]) * 4;
            for (int i = 0; i < 4; i++) n_if_rdata[8*i +: 8] = shadow[base + i];
        end else if (g == 2) begin
            sz   = (bus.d_size == 2'd0) ? 1 : (bus.d_size == 2'd1) ? 2 : 4;
            o    = int'(bus.d_addr[1:0]);
            base = int'(bus.d_addr[8:0]);
            if ((base % sz) != 0) begin
                n_mis = 1; chk_a = 0; chk_wd = 0;
            end else if (bus.d_we) begin
                x_we  = 1;
                x_a   = bus.d_addr & ~32'h3;
                x_wbe = 4'(((1 << sz) - 1) << o);
                for (int k = 0; k < 4; k++) x_wd[8*k +: 8] = bus.d_wdata[8*(k % sz) +: 8];
                for (int i = 0; i < sz; i++) shadow[base + i] = bus.d_wdata[8*i +: 8];
            end else begin
                chk_wd = 0;
                x_a    = bus.d_addr & ~32'h3;
                v      = 0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = shadow[base + i];
                if (!bus.d_unsigned && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
                n_d_rdata = v;
            end
        end

        if (m_valid) begin
            chk("mem_we",  32'(bus.mem_we),  32'(x_we));
            chk("mem_wbe", 32'(bus.mem_wbe), 32'(x_wbe));
            if (chk_a)  chk("mem_a",  bus.mem_a,  x_a);
            if (chk_wd) chk("mem_wd", bus.mem_wd, x_wd);
        end

        if (!rst_n) begin
            m_busy = 0; m_last_d = 0; e_if_ready = 0; e_d_ready = 0; e_d_mis = 0;
            m_valid = 1;
        end else if (m_busy) begin
            m_busy = 0; e_if_ready = 0; e_d_ready = 0;
        end else if (g != 0) begin
            m_busy     = 1;
            m_last_d   = (g == 2);
            e_if_ready = (g == 1);
            e_d_ready  = (g == 2);
            if (g == 1) e_if_rdata = n_if_rdata;
            else begin
                e_d_rdata = n_d_rdata;
                e_d_mis   = n_mis;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed data access; assumes the fetch side is idle
    // ------------------------------------------------------------------
    task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic uns,
                            output logic [31:0] rdata, output logic mis,
                            output logic [3:0] wbe, output int lat);
        bit got;
        @(posedge clk); #1;
        bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        bus.d_size = size; bus.d_unsigned = uns; bus.d_req = 1'b1;
        @(negedge clk);
        wbe = bus.mem_wbe;
        lat = 0; got = 0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            got = bus.d_ready;
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL d_access_timeout: got no d_ready expected d_ready within 10 cycles");
        end
        rdata = bus.d_rdata;
        mis   = bus.d_misaligned;
        @(posedge clk); #1;
        bus.d_req = 1'b0;
    endtask

    task automatic fetch_requester(input int n);
        int cnt;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.if_req = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            bus.if_addr = $urandom;
            bus.if_req  = 1'b1;
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (!bus.if_ready && cnt < 8);
            n_checks++;
            if (!bus.if_ready || cnt > 4) begin
                n_fail++;
                $display("FAIL fetch_wait: got %0d cycles expected at most 4", cnt);
            end
            @(posedge clk); #1;
        end
        bus.if_req = 1'b0;
    endtask

    task automatic data_requester(input int n);
        int cnt;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.d_req = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            bus.d_addr     = {($urandom_range(0, 3) == 0) ? 23'($urandom) : 23'h0, 9'($urandom)};
            bus.d_we       = 1'($urandom);
            bus.d_wdata    = $urandom;
            bus.d_size     = 2'($urandom);
            bus.d_unsigned = 1'($urandom);
            bus.d_req      = 1'b1;
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (!bus.d_ready && cnt < 8);
            n_checks++;
            if (!bus.d_ready || cnt > 4) begin
                n_fail++;
                $display("FAIL data_wait: got %0d cycles expected at most 4", cnt);
            end
            @(posedge clk); #1;
        end
        bus.d_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        mis;
        logic [3:0]  wbe;
        int          lat;
        logic        d_seen [1:8];
        logic        f_seen [1:8];
        logic [31:0] r;

        for (int w = 0; w < 128; w++) begin
            r = $urandom;
            ram[w] = r;
            for (int b = 0; b < 4; b++) shadow[4*w + b] = r[8*b +: 8];
        end

        rst_n = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40; bus.d_wdata = 32'h0;
        bus.d_size = 2'd2; bus.d_unsigned = 1'b0;

        // Reset held with both requesters active
        repeat (3) begin
            @(negedge clk);
            chk("reset_if_ready", 32'(bus.if_ready), 32'h0);
            chk("reset_d_ready",  32'(bus.d_ready),  32'h0);
            chk("reset_mem_we",   32'(bus.mem_we),   32'h0);
        end
        chk("reset_if_rdata", bus.if_rdata, 32'h0);
        chk("reset_d_rdata",  bus.d_rdata,  32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Contention straight out of reset: D, F, D, F
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            d_seen[k] = bus.d_ready;
            f_seen[k] = bus.if_ready;
        end
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("contention_d_ready_c%0d", k), 32'(d_seen[k]), (k == 2 || k == 6) ? 32'h1 : 32'h0);
            chk($sformatf("contention_if_ready_c%0d", k), 32'(f_seen[k]), (k == 4 || k == 8) ? 32'h1 : 32'h0);
        end
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.d_req = 1'b0;

        // Word store / load
        d_access(1'b1, 32'h40, 32'hDEAD_BEEF, 2'd2, 1'b0, rd, mis, wbe, lat);
        chk("sw_wbe", 32'(wbe), 32'hF);
        chk("sw_latency", 32'(lat), 32'h1);
        chk("sw_rdata", rd, 32'h0);
        d_access(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, rd, mis, wbe, lat);
        chk("lw_rdata", rd, 32'hDEAD_BEEF);
        chk("lw_latency", 32'(lat), 32'h1);

        // Byte store and extension
        d_access(1'b1, 32'h43, 32'h0000_0080, 2'd0, 1'b0, rd, mis, wbe, lat);
        chk("sb_wbe", 32'(wbe), 32'h8);
        d_access(1'b0, 32'h43, 32'h0, 2'd0, 1'b0, rd, mis, wbe, lat);
        chk("lb_signed", rd, 32'hFFFF_FF80);
        d_access(1'b0, 32'h43, 32'h0, 2'd0, 1'b1, rd, mis, wbe, lat);
        chk("lbu_unsigned", rd, 32'h0000_0080);
        d_access(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, rd, mis, wbe, lat);
        chk("lw_after_sb", rd, 32'h80AD_BEEF);

        // Misaligned accesses leave the RAM alone
        d_access(1'b1, 32'h41, 32'h0000_1234, 2'd1, 1'b0, rd, mis, wbe, lat);
        chk("sh_mis_flag", 32'(mis), 32'h1);
        chk("sh_mis_wbe",  32'(wbe), 32'h0);
        chk("sh_mis_rdata", rd, 32'h0);
        d_access(1'b0, 32'h46, 32'h0, 2'd2, 1'b0, rd, mis, wbe, lat);
        chk("lw_mis_flag", 32'(mis), 32'h1);
        chk("lw_mis_rdata", rd, 32'h0);
        d_access(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, rd, mis, wbe, lat);
        chk("lw_after_mis", rd, 32'h80AD_BEEF);

        // Reset during an access: no ready pulse, store stays written
        @(posedge clk); #1;
        bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'h1234_5678;
        bus.d_size = 2'd2; bus.d_req = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_we", 32'(bus.mem_we), 32'h1);
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_d_ready", 32'(bus.d_ready), 32'h0);
        end
        @(posedge clk); #1;
        bus.d_req = 1'b0; rst_n = 1'b1;
        d_access(1'b0, 32'h80, 32'h0, 2'd2, 1'b0, rd, mis, wbe, lat);
        chk("lw_after_rst", rd, 32'h1234_5678);

        // Randomized concurrent traffic
        @(posedge clk); #1;
        fork
            fetch_requester(120);
            data_requester(120);
        join

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
